cp0_exc_ctrl: RTL and testbench
===============================

Name: cp0_exc_ctrl

Overview:
Exception/interrupt commit controller that sequences the CP0 register file and the front end on every trap.
- Sits at the WB boundary.
- Arbitrates between three sources on the instruction in WB: synchronized hardware interrupts, synchronous exceptions and ERET.
- Issues single-cycle CP0 update strobes and a pipeline flush.
- Holds a redirect handshake with fetch.
- Enforces a post-trap blanking window so CP0 Status/Cause writes settle before interrupts are re-sampled.

Parameters:
EXC_VECTOR, 32'hBFC00380, general exception entry PC
SYNC_STAGES, 2, flop depth of the ext_int synchronizer (>=2)
BLANK_CYCLES, 2, cycles after redirect acceptance during which interrupts are not taken (>=1)

Ports:
clk  in  1  clock, all logic rising edge
rst_n  in  1  asynchronous active-low reset
wb_valid  in  1  a valid instruction occupies WB this cycle
wb_exc_req  in  1  WB instruction carries a synchronous exception
wb_exc_code  in  5  ExcCode of that exception
wb_eret  in  1  WB instruction is ERET
wb_bd  in  1  WB instruction is in a branch delay slot
wb_pc  in  32  PC of WB instruction
wb_badvaddr  in  32  faulting virtual address (AdEL/AdES only)
ext_int  in  6  asynchronous hardware interrupt lines
timer_int  in  1  Count==Compare timer interrupt (synchronous, from CP0)
cause_ip_sw  in  2  Cause.IP[1:0]
status_im  in  8  Status.IM
status_ie  in  1  Status.IE
status_exl  in  1  Status.EXL
epc  in  32  current CP0 EPC
redirect_ready  in  1  fetch accepts redirect
ip_hw  out  6  synchronized hardware IP to CP0 Cause.IP[7:2] (bit 5 ORed with timer_int)
cp0_exc_we  out  1  one-cycle strobe: CP0 writes EPC/Cause.BD/ExcCode/BadVAddr, sets EXL
cp0_eret_we  out  1  one-cycle strobe: CP0 clears EXL
exc_code_o  out  5  latched ExcCode (0 for interrupt)
exc_bd_o  out  1  latched BD
exc_pc_o  out  32  latched PC of trapping instruction
exc_badvaddr_o  out  32  latched bad address
flush  out  1  one-cycle pipeline flush pulse
stall_wb  out  1  WB must hold/suppress commit
redirect_valid  out  1  redirect request to fetch
redirect_pc  out  32  target PC

Behaviour:
- Reset (async, rst_n=0): state IDLE, blank counter 0, synchronizer flops 0; all outputs 0 (redirect_pc, exc_*_o = 0).
- Synchronizer: ext_int passes through SYNC_STAGES flops; ip_hw = sync_out | {timer_int,5'b0}.
- pending = {ip_hw, cause_ip_sw} & status_im.
- int_req = |pending & status_ie & !status_exl & (blank_cnt==0).
- Event detection, IDLE only, requires wb_valid. Priority is interrupt > wb_exc_req > wb_eret.
  - An interrupt preempts that instruction's own exception or ERET, and that instruction does not commit.
- stall_wb is combinational: high in any non-IDLE state, and in IDLE in the detection cycle.
- FSM states:
  - IDLE, event at cycle T: latch code (0 for interrupt), bd, pc and badvaddr. Set redirect_pc to EPC if ERET, else EXC_VECTOR. Go to COMMIT.
  - COMMIT (T+1): pulse flush plus exactly one of cp0_exc_we / cp0_eret_we. Assert redirect_valid. Go to REDIRECT.
  - REDIRECT: hold redirect_valid and redirect_pc stable until redirect_ready is high. On that handshake cycle, drop redirect_valid next cycle, load blank_cnt=BLANK_CYCLES, go to IDLE.
  - COMMIT also completes the handshake if redirect_ready is already high in that cycle; in that case it goes directly to IDLE with blanking.
- Blanking: blank_cnt decrements each cycle in IDLE down to 0. Synchronous exceptions and ERET are still accepted while blank_cnt != 0; only interrupts are deferred.
- While not IDLE, WB inputs are ignored; no second event is queued.
- ERET with redirect_pc latched from epc in the detection cycle, not COMMIT.
- Reset asserted mid-REDIRECT aborts immediately: redirect_valid=0, no further strobes.

Test Plan:
1. Reset then wb_valid=1, wb_exc_req=1, code=5'h04, pc=32'h8000_0010, badvaddr=32'h1 -> T+1: flush=1, cp0_exc_we=1, exc_code_o=4, exc_badvaddr_o=1, redirect_pc=32'hBFC00380; both strobes one cycle only.
2. Same cycle: ext_int[0]=1 (stable > SYNC_STAGES cycles), im[2]=1, ie=1, exl=0, plus wb_exc_req code 8 -> interrupt wins: exc_code_o=0, exc_pc_o=wb_pc.
3. wb_eret=1, epc=32'h8000_1234 -> cp0_eret_we=1, cp0_exc_we=0, redirect_pc=32'h8000_1234.
4. redirect_ready held 0 for 5 cycles -> redirect_valid/redirect_pc stable, stall_wb=1 throughout; on ready=1, back to IDLE next cycle.
5. Interrupt pending right after redirect -> not taken for BLANK_CYCLES cycles; a wb_exc_req in that window is taken; the interrupt is taken after the window.
6. Assert rst_n=0 in REDIRECT -> all outputs 0 immediately (asynchronous); after release, state IDLE, no stray strobe.

Source files
------------

// File: rtl/cp0_exc_ctrl.sv
// cp0_exc_ctrl: WB-boundary trap sequencer driving CP0 update strobes, flush and fetch redirect
module cp0_exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
  parameter int          SYNC_STAGES  = 2,
  parameter int          BLANK_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_valid,
  input  logic        wb_exc_req,
  input  logic [4:0]  wb_exc_code,
  input  logic        wb_eret,
  input  logic        wb_bd,
  input  logic [31:0] wb_pc,
  input  logic [31:0] wb_badvaddr,
  input  logic [5:0]  ext_int,
  input  logic        timer_int,
  input  logic [1:0]  cause_ip_sw,
  input  logic [7:0]  status_im,
  input  logic        status_ie,
  input  logic        status_exl,
  input  logic [31:0] epc,
  input  logic        redirect_ready,
  output logic [5:0]  ip_hw,
  output logic        cp0_exc_we,
  output logic        cp0_eret_we,
  output logic [4:0]  exc_code_o,
  output logic        exc_bd_o,
  output logic [31:0] exc_pc_o,
  output logic [31:0] exc_badvaddr_o,
  output logic        flush,
  output logic        stall_wb,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);
  localparam int BW = $clog2(BLANK_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, COMMIT, REDIRECT} state_t;
  state_t state, state_nx;
  logic [5:0] sync_q [SYNC_STAGES];
  logic [BW-1:0] blank_cnt;
  logic [7:0] pending;
  logic int_req, ev, take_eret, is_eret, hs;
  assign ip_hw = sync_q[SYNC_STAGES-1] | {timer_int, 5'b0};
  assign pending = {ip_hw, cause_ip_sw} & status_im;
  assign int_req = |pending && status_ie && !status_exl && blank_cnt == '0;
  assign ev = state == IDLE && wb_valid && (int_req || wb_exc_req || wb_eret);
  assign take_eret = !int_req && !wb_exc_req && wb_eret;
  assign hs = state != IDLE && redirect_ready;
  // ext_int synchronizer chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '{default: '0};
    else begin
      sync_q[0] <= ext_int;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  // next state: COMMIT can finish the handshake itself when fetch is already ready
  always_comb begin
    state_nx = state == IDLE ? (ev ? COMMIT : IDLE) : (redirect_ready ? IDLE : REDIRECT);
  end
  // outputs decoded from state; stall also covers the detection cycle
  always_comb begin
    flush = state == COMMIT;
    cp0_exc_we = flush && !is_eret;
    cp0_eret_we = flush && is_eret;
    redirect_valid = state != IDLE;
    stall_wb = state != IDLE || ev;
  end
  // interrupt blanking window after each accepted redirect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) blank_cnt <= '0;
    else if (hs) blank_cnt <= BW'(BLANK_CYCLES);
    else if (state == IDLE && blank_cnt != '0) blank_cnt <= blank_cnt - BW'(1);
  end
  // trap record and redirect target captured in the detection cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_eret <= 1'b0;
      exc_code_o <= '0;
      exc_bd_o <= 1'b0;
      exc_pc_o <= '0;
      exc_badvaddr_o <= '0;
      redirect_pc <= '0;
    end else if (ev) begin
      is_eret <= take_eret;
      exc_code_o <= int_req ? 5'd0 : wb_exc_code;
      exc_bd_o <= wb_bd;
      exc_pc_o <= wb_pc;
      exc_badvaddr_o <= wb_badvaddr;
      redirect_pc <= take_eret ? epc : EXC_VECTOR;
    end
  end
endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// tb_cp0_exc_ctrl: scenario and randomized checks of cp0_exc_ctrl against a trap-rule model
module tb_cp0_exc_ctrl;
  localparam logic [31:0] VEC = 32'hBFC00380;
  localparam int SS = 2;
  localparam int BC = 2;
  logic clk = 0, rst_n = 0;
  logic wb_valid = 0, wb_exc_req = 0, wb_eret = 0, wb_bd = 0, timer_int = 0, status_ie = 0, status_exl = 0, redirect_ready = 0;
  logic [4:0] wb_exc_code = 0;
  logic [31:0] wb_pc = 0, wb_badvaddr = 0, epc = 0;
  logic [5:0] ext_int = 0;
  logic [1:0] cause_ip_sw = 0;
  logic [7:0] status_im = 0;
  logic [5:0] ip_hw;
  logic cp0_exc_we, cp0_eret_we, exc_bd_o, flush, stall_wb, redirect_valid;
  logic [4:0] exc_code_o;
  logic [31:0] exc_pc_o, exc_badvaddr_o, redirect_pc;
  int tests = 0, fails = 0;

  cp0_exc_ctrl #(.EXC_VECTOR(VEC), .SYNC_STAGES(SS), .BLANK_CYCLES(BC)) dut (
    .clk(clk), .rst_n(rst_n), .wb_valid(wb_valid), .wb_exc_req(wb_exc_req), .wb_exc_code(wb_exc_code),
    .wb_eret(wb_eret), .wb_bd(wb_bd), .wb_pc(wb_pc), .wb_badvaddr(wb_badvaddr), .ext_int(ext_int),
    .timer_int(timer_int), .cause_ip_sw(cause_ip_sw), .status_im(status_im), .status_ie(status_ie),
    .status_exl(status_exl), .epc(epc), .redirect_ready(redirect_ready), .ip_hw(ip_hw),
    .cp0_exc_we(cp0_exc_we), .cp0_eret_we(cp0_eret_we), .exc_code_o(exc_code_o), .exc_bd_o(exc_bd_o),
    .exc_pc_o(exc_pc_o), .exc_badvaddr_o(exc_badvaddr_o), .flush(flush), .stall_wb(stall_wb),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc));

  always #5 clk = ~clk;

  // 0 none, 1 interrupt, 2 exception, 3 eret; assumes blanking has expired
  function automatic int exp_kind();
    logic [7:0] ip;
    logic irq = 0;
    for (int i = 0; i < 8; i++) begin
      ip[i] = i < 2 ? cause_ip_sw[i] : i == 7 ? (ext_int[5] | timer_int) : ext_int[i-2];
      if (ip[i] && status_im[i]) irq = 1;
    end
    irq = irq && status_ie && !status_exl;
    if (!wb_valid) return 0;
    if (irq) return 1;
    if (wb_exc_req) return 2;
    if (wb_eret) return 3;
    return 0;
  endfunction

  // called #1 after a rising edge with the trapping instruction already driven in WB
  task automatic do_trap(input string nm, input bit e_eret, input logic [4:0] e_code, input logic [31:0] e_pc,
                         input logic [31:0] e_bad, input logic [31:0] e_tgt, input logic e_bd, input int delay);
    #1;
    tests++; if (stall_wb !== 1'b1) begin fails++; $display("FAIL %s detect stall_wb got %b want 1", nm, stall_wb); end
    redirect_ready = (delay == 0);
    @(posedge clk); #1;
    wb_valid = 0;
    tests++; if ({flush, cp0_exc_we, cp0_eret_we, redirect_valid} !== {1'b1, !e_eret, e_eret, 1'b1}) begin
      fails++; $display("FAIL %s commit flush/exc/eret/rv got %b%b%b%b want 1%b%b1", nm, flush, cp0_exc_we, cp0_eret_we, redirect_valid, !e_eret, e_eret); end
    tests++; if (redirect_pc !== e_tgt) begin fails++; $display("FAIL %s redirect_pc got %h want %h", nm, redirect_pc, e_tgt); end
    tests++; if (exc_pc_o !== e_pc || exc_bd_o !== e_bd) begin fails++; $display("FAIL %s pc/bd got %h/%b want %h/%b", nm, exc_pc_o, exc_bd_o, e_pc, e_bd); end
    if (!e_eret) begin
      tests++; if (exc_code_o !== e_code || exc_badvaddr_o !== e_bad) begin
        fails++; $display("FAIL %s code/badvaddr got %h/%h want %h/%h", nm, exc_code_o, exc_badvaddr_o, e_code, e_bad); end
    end
    for (int k = 1; k <= delay; k++) begin
      @(posedge clk); #1;
      tests++; if ({flush, cp0_exc_we, cp0_eret_we, redirect_valid, stall_wb} !== 5'b00011 || redirect_pc !== e_tgt) begin
        fails++; $display("FAIL %s hold%0d f/e/r/rv/st got %b%b%b%b%b pc %h want 00011 pc %h", nm, k, flush, cp0_exc_we, cp0_eret_we, redirect_valid, stall_wb, redirect_pc, e_tgt); end
      redirect_ready = (k == delay);
    end
    @(posedge clk); #1;
    redirect_ready = 0;
    tests++; if ({flush, cp0_exc_we, cp0_eret_we, redirect_valid, stall_wb} !== 5'b0) begin
      fails++; $display("FAIL %s after handshake f/e/r/rv/st got %b%b%b%b%b want 00000", nm, flush, cp0_exc_we, cp0_eret_we, redirect_valid, stall_wb); end
  endtask

  task automatic idle(input int n);
    wb_valid = 0; wb_exc_req = 0; wb_eret = 0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    tests++; if ({ip_hw, cp0_exc_we, cp0_eret_we, flush, stall_wb, redirect_valid, exc_bd_o} !== '0) begin
      fails++; $display("FAIL reset ctrl ip=%h e=%b r=%b f=%b st=%b rv=%b bd=%b want 0", ip_hw, cp0_exc_we, cp0_eret_we, flush, stall_wb, redirect_valid, exc_bd_o); end
    tests++; if ({redirect_pc, exc_pc_o, exc_badvaddr_o, exc_code_o} !== '0) begin
      fails++; $display("FAIL reset data rpc=%h pc=%h bad=%h code=%h want 0", redirect_pc, exc_pc_o, exc_badvaddr_o, exc_code_o); end
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_exception();
    wb_valid = 1; wb_exc_req = 1; wb_exc_code = 5'h04; wb_pc = 32'h8000_0010; wb_badvaddr = 32'h1; wb_bd = 0;
    do_trap("exc", 0, 5'h04, 32'h8000_0010, 32'h1, VEC, 0, 0);
    idle(BC + 1);
  endtask

  task automatic test_int_priority();
    ext_int = 6'b000001; status_im = 8'h04; status_ie = 1; status_exl = 0;
    idle(SS + 1);
    tests++; if (ip_hw !== 6'b000001) begin fails++; $display("FAIL sync ip_hw got %h want 01", ip_hw); end
    wb_valid = 1; wb_exc_req = 1; wb_exc_code = 5'h08; wb_pc = 32'h8000_0200; wb_badvaddr = 32'h55; wb_bd = 1;
    do_trap("int_prio", 0, 5'h00, 32'h8000_0200, 32'h55, VEC, 1, 0);
    ext_int = 0; status_im = 0; status_ie = 0; wb_bd = 0;
    idle(BC + SS + 1);
  endtask

  task automatic test_eret();
    epc = 32'h8000_1234; wb_valid = 1; wb_eret = 1; wb_pc = 32'h8000_0300;
    do_trap("eret", 1, 5'h00, 32'h8000_0300, 32'h0, 32'h8000_1234, 0, 0);
    idle(BC + 1);
  endtask

  task automatic test_stall_hold();
    wb_valid = 1; wb_exc_req = 1; wb_exc_code = 5'h0c; wb_pc = 32'h8000_0400; wb_badvaddr = 32'h0;
    do_trap("hold", 0, 5'h0c, 32'h8000_0400, 32'h0, VEC, 0, 5);
    idle(BC + 1);
  endtask

  task automatic test_blanking();
    ext_int = 6'b000010; status_im = 8'h08; status_ie = 1;
    idle(SS + BC);
    wb_valid = 1; wb_pc = 32'h8000_0500; wb_badvaddr = 0;
    do_trap("blank_int1", 0, 5'h00, 32'h8000_0500, 32'h0, VEC, 0, 0);
    for (int k = 0; k < BC - 1; k++) begin
      wb_valid = 1; wb_pc = 32'h8000_0504 + k;
      #1;
      tests++; if (stall_wb !== 1'b0) begin fails++; $display("FAIL blank_defer%0d stall_wb got %b want 0", k, stall_wb); end
      @(posedge clk); #1;
    end
    wb_valid = 1; wb_exc_req = 1; wb_exc_code = 5'h0a; wb_pc = 32'h8000_0600; wb_badvaddr = 32'h9;
    do_trap("blank_exc", 0, 5'h0a, 32'h8000_0600, 32'h9, VEC, 0, 0);
    wb_exc_req = 0;
    for (int k = 0; k < BC; k++) begin
      wb_valid = 1; wb_pc = 32'h8000_0700 + k;
      #1;
      tests++; if (stall_wb !== 1'b0) begin fails++; $display("FAIL blank_defer2_%0d stall_wb got %b want 0", k, stall_wb); end
      @(posedge clk); #1;
    end
    wb_valid = 1; wb_pc = 32'h8000_0800; wb_badvaddr = 32'h3;
    do_trap("blank_int2", 0, 5'h00, 32'h8000_0800, 32'h3, VEC, 0, 0);
    ext_int = 0; status_im = 0; status_ie = 0;
    idle(BC + SS + 1);
  endtask

  task automatic test_reset_mid();
    wb_valid = 1; wb_exc_req = 1; wb_exc_code = 5'h05; wb_pc = 32'h8000_0900; wb_badvaddr = 32'h77; redirect_ready = 0;
    @(posedge clk); #1;
    idle(1);
    tests++; if (redirect_valid !== 1'b1) begin fails++; $display("FAIL rstmid pre redirect_valid got %b want 1", redirect_valid); end
    #2 rst_n = 0;
    #1;
    tests++; if ({redirect_valid, flush, cp0_exc_we, cp0_eret_we, stall_wb} !== 5'b0 || redirect_pc !== 0 || exc_pc_o !== 0 || exc_badvaddr_o !== 0 || exc_code_o !== 0) begin
      fails++; $display("FAIL rstmid async rv=%b f=%b e=%b r=%b st=%b rpc=%h pc=%h want all 0", redirect_valid, flush, cp0_exc_we, cp0_eret_we, stall_wb, redirect_pc, exc_pc_o); end
    @(negedge clk); rst_n = 1; redirect_ready = 1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      tests++; if ({redirect_valid, flush, cp0_exc_we, cp0_eret_we, stall_wb} !== 5'b0) begin
        fails++; $display("FAIL rstmid post%0d rv=%b f=%b e=%b r=%b st=%b want 0", k, redirect_valid, flush, cp0_exc_we, cp0_eret_we, stall_wb); end
    end
    redirect_ready = 0;
  endtask

  task automatic test_random();
    int kd;
    for (int n = 0; n < 40; n++) begin
      ext_int = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0;
      timer_int = ($urandom_range(0, 4) == 0);
      cause_ip_sw = 2'($urandom);
      status_im = 8'($urandom);
      status_ie = ($urandom_range(0, 3) != 0);
      status_exl = ($urandom_range(0, 3) == 0);
      idle(SS + BC);
      tests++; if (ip_hw !== (ext_int | {timer_int, 5'b0})) begin
        fails++; $display("FAIL rnd%0d ip_hw got %h want %h", n, ip_hw, ext_int | {timer_int, 5'b0}); end
      wb_valid = ($urandom_range(0, 5) != 0);
      wb_exc_req = $urandom_range(0, 1); wb_eret = $urandom_range(0, 1);
      wb_exc_code = 5'($urandom); wb_bd = $urandom_range(0, 1);
      wb_pc = $urandom; wb_badvaddr = $urandom; epc = $urandom;
      kd = exp_kind();
      if (kd == 0) begin
        #1;
        tests++; if (stall_wb !== 1'b0) begin fails++; $display("FAIL rnd%0d none stall_wb got %b want 0", n, stall_wb); end
        @(posedge clk); #1;
        tests++; if ({flush, redirect_valid} !== 2'b0) begin fails++; $display("FAIL rnd%0d none flush/rv got %b%b want 00", n, flush, redirect_valid); end
      end else
        do_trap($sformatf("rnd%0d", n), kd == 3, kd == 1 ? 5'd0 : wb_exc_code, wb_pc, wb_badvaddr,
                kd == 3 ? epc : VEC, wb_bd, $urandom_range(0, 3));
    end
  endtask

  initial begin
    test_reset();
    test_exception();
    test_int_priority();
    test_eret();
    test_stall_hold();
    test_blanking();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
